// File: rtl/bram_axis_reader_pkg.sv
// Shared widths, derived beat count and FSM states for the BRAM-to-AXIS reader.
// No ports: imported by the reader, its serializer and its stream interface.
package bram_axis_reader_pkg;

  localparam int BRAM_DW = 1152;
  localparam int AXIS_DW = 32;
  localparam int ADDR_W  = 12;
  localparam int WORDS   = BRAM_DW / AXIS_DW;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    STREAM,
    FINISH
  } state_t;

endpackage

// File: rtl/bram_axis_reader_if.sv
// AXI4-Stream master/slave bundle used by the reader output.
// Signals: tvalid, tdata, tstrb, tlast (master out), tready (slave out).
interface bram_axis_reader_if #(
  parameter int DW = bram_axis_reader_pkg::AXIS_DW
);

  logic          tvalid;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic          tlast;
  logic          tready;

  modport master (
    output tvalid,
    output tdata,
    output tstrb,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tstrb,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/bram_line_serializer.sv
// Holds one BRAM line and presents it as LSB-first beats.
// Ports: clk, rst, load, advance, line_in -> beat, last (final beat of the line).
module bram_line_serializer
  import bram_axis_reader_pkg::*;
#(
  parameter int LW = BRAM_DW,
  parameter int BW = AXIS_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [LW-1:0] line_in,
  output logic [BW-1:0] beat,
  output logic          last
);

  localparam int N  = LW / BW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [LW-1:0] line_q;
  logic [CW-1:0] cnt_q;

  // Shifting the line down keeps the current beat in the low
  // word, replacing a wide N:1 mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      line_q <= line_in;
      cnt_q  <= '0;
    end else if (advance) begin
      line_q <= line_q >> BW;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign beat = line_q[BW-1:0];
  assign last = (cnt_q == CW'(N - 1));

endmodule

// File: rtl/bram_axis_reader.sv
// Streams BRAM lines start..bound (inclusive) out as AXIS beats.
// Ports: m00_axis_aclk/areset, BRAM_* read port, m00_axis stream, start/addrs, busy/done.
module bram_axis_reader
  import bram_axis_reader_pkg::*;
#(
  parameter int BRAM_DATA_WIDTH = BRAM_DW,
  parameter int AXIS_DATA_WIDTH = AXIS_DW,
  parameter int BRAM_ADDR_WIDTH = ADDR_W
) (
  input  logic                       m00_axis_aclk,
  input  logic                       m00_axis_areset,
  output logic                       BRAM_CLK,
  output logic                       BRAM_EN,
  output logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR,
  input  logic [BRAM_DATA_WIDTH-1:0] BRAM_OUT,
  bram_axis_reader_if.master         m00_axis,
  input  logic                       start,
  input  logic [BRAM_ADDR_WIDTH-1:0] bram_start_addr,
  input  logic [BRAM_ADDR_WIDTH-1:0] bram_bound_addr,
  output logic                       busy,
  output logic                       done
);

  localparam int SW = AXIS_DATA_WIDTH / 8;

  logic clk;
  logic rst;

  assign clk      = m00_axis_aclk;
  assign rst      = m00_axis_areset;
  assign BRAM_CLK = m00_axis_aclk;

  state_t state_q;
  state_t state_d;

  logic [BRAM_ADDR_WIDTH-1:0] line_q;
  logic [BRAM_ADDR_WIDTH-1:0] bound_q;
  logic [AXIS_DATA_WIDTH-1:0] beat;
  logic beat_last;
  logic at_bound;
  logic fire;
  logic tvalid;

  assign at_bound = (line_q == bound_q);
  assign fire     = (state_q == STREAM) && m00_axis.tready;

  bram_line_serializer #(
    .LW (BRAM_DATA_WIDTH),
    .BW (AXIS_DATA_WIDTH)
  ) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (state_q == WAIT),
    .advance (fire),
    .line_in (BRAM_OUT),
    .beat    (beat),
    .last    (beat_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (bram_start_addr > bram_bound_addr)
            state_d = FINISH;
          else
            state_d = FETCH;
        end
      end
      FETCH:  state_d = WAIT;
      WAIT:   state_d = STREAM;
      STREAM: begin
        if (fire && beat_last)
          state_d = at_bound ? FINISH : FETCH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address compare happens before increment, so a bound of
  // all-ones ends the run without ever wrapping line_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q  <= '0;
      bound_q <= '0;
    end else if (state_q == IDLE && start) begin
      line_q  <= bram_start_addr;
      bound_q <= bram_bound_addr;
    end else if (fire && beat_last && !at_bound) begin
      line_q  <= line_q + 1'b1;
    end
  end

  always_comb begin
    BRAM_EN = 1'b0;
    tvalid  = 1'b0;
    done    = 1'b0;
    busy    = 1'b1;
    case (state_q)
      IDLE:    busy    = 1'b0;
      FETCH:   BRAM_EN = 1'b1;
      STREAM:  tvalid  = 1'b1;
      FINISH:  done    = 1'b1;
      default: ;
    endcase
  end

  assign BRAM_ADDR      = line_q;
  assign m00_axis.tvalid = tvalid;
  assign m00_axis.tdata  = beat;
  assign m00_axis.tlast  = tvalid && beat_last && at_bound;
  assign m00_axis.tstrb  = {SW{tvalid}};

endmodule

// File: tb/tb_bram_axis_reader.sv
// Testbench for bram_axis_reader: vector table plus reset/busy corner sequences.
// Ports: none.
module tb_bram_axis_reader;

  localparam int LW = 1152;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NW = LW / DW;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  typedef struct {
    int s;
    int b;
    bit tog;
    int nb;
    int nl;
    int f;
    int l;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          bram_clk;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [LW-1:0] bram_out = '0;
  logic          start;
  logic [AW-1:0] s_addr;
  logic [AW-1:0] b_addr;
  logic          busy;
  logic          done;
  logic          toggle = 1'b0;

  bram_axis_reader_if #(.DW(DW)) axis ();

  bram_axis_reader #(
    .BRAM_DATA_WIDTH (LW),
    .AXIS_DATA_WIDTH (DW),
    .BRAM_ADDR_WIDTH (AW)
  ) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_areset (rst),
    .BRAM_CLK        (bram_clk),
    .BRAM_EN         (bram_en),
    .BRAM_ADDR       (bram_addr),
    .BRAM_OUT        (bram_out),
    .m00_axis        (axis),
    .start           (start),
    .bram_start_addr (s_addr),
    .bram_bound_addr (b_addr),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int dones  = 0;
  int ens    = 0;
  int first_d = 0;
  int last_d  = 0;
  exp_t q[$];

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < NW; k++)
      l[k*DW +: DW] = DW'(int'(a) * 100 + k);
    return l;
  endfunction

  always @(posedge clk)
    if (bram_en) bram_out <= line_of(bram_addr);

  always @(posedge clk) begin
    #1;
    axis.tready = toggle ? !axis.tready : 1'b1;
  end

  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [DW-1:0] pd = '0;
  logic          pl = 1'b0;
  bit            seen = 0;
  int            low = 0;

  always @(negedge clk) begin
    exp_t e;
    if (axis.tvalid) begin
      check("tstrb", axis.tstrb, 4'hf);
      if (axis.tready) begin
        beats++;
        if (beats == 1) first_d = int'(axis.tdata);
        last_d = int'(axis.tdata);
        if (q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = q.pop_front();
          check("tdata", axis.tdata, e.d);
          check("tlast", axis.tlast, e.l);
        end
      end
    end
    if (pv && !pr && !rst) begin
      check("stall_valid", axis.tvalid, 1);
      check("stall_data", axis.tdata, pd);
      check("stall_last", axis.tlast, pl);
    end
    if (!busy) begin
      seen = 0;
      low  = 0;
    end else if (axis.tvalid) begin
      if (seen && low != 0) check("gap_len", low, 2);
      seen = 1;
      low  = 0;
    end else if (seen) begin
      low++;
    end
    if (done) dones++;
    if (bram_en) ens++;
    pv = axis.tvalid;
    pr = axis.tready;
    pd = axis.tdata;
    pl = axis.tlast;
  end

  task automatic launch(input int s, input int b);
    for (int a = s; a <= b; a++)
      for (int k = 0; k < NW; k++)
        q.push_back('{DW'(a * 100 + k), (a == b && k == NW - 1)});
    beats = 0;
    dones = 0;
    ens   = 0;
    first_d = 0;
    last_d  = 0;
    @(posedge clk); #1;
    s_addr = AW'(s);
    b_addr = AW'(b);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (s <= b) begin
      check("lat_en", bram_en, 1);
      check("lat_addr", bram_addr, s);
      check("lat_busy", busy, 1);
      @(posedge clk); #1;
      check("lat_wait_en", bram_en, 0);
      check("lat_wait_valid", axis.tvalid, 0);
      @(posedge clk); #1;
      check("lat_valid", axis.tvalid, 1);
    end else begin
      check("empty_done", done, 1);
      check("empty_busy", busy, 1);
      @(posedge clk); #1;
      check("empty_done_end", done, 0);
      check("empty_idle", busy, 0);
    end
  endtask

  task automatic finish_check(input int nb, input int nl,
                              input int f, input int l);
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check("beat_count", beats, nb);
    check("done_count", dones, 1);
    check("en_count", ens, nl);
    check("queue_left", q.size(), 0);
    if (nb > 0) begin
      check("first_beat", first_d, f);
      check("last_beat", last_d, l);
    end
  endtask

  vec_t tv[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0] = '{3, 7, 1'b0, 180, 5, 300, 735};
    tv[1] = '{5, 5, 1'b1, 36, 1, 500, 535};
    tv[2] = '{9, 4, 1'b0, 0, 0, 0, 0};
    tv[3] = '{4094, 4095, 1'b0, 72, 2, 409400, 409535};

    rst    = 1'b1;
    start  = 1'b0;
    s_addr = '0;
    b_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_tlast", axis.tlast, 0);
    check("rst_en", bram_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_tdata", axis.tdata, 0);
    check("rst_tstrb", axis.tstrb, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      toggle = tv[i].tog;
      launch(tv[i].s, tv[i].b);
      finish_check(tv[i].nb, tv[i].nl, tv[i].f, tv[i].l);
      toggle = 1'b0;
      repeat (2) @(posedge clk);
    end

    begin
      int n = 0;
      launch(3, 7);
      while (beats < NW + 20 && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      check("rst_reach", beats, NW + 20);
      check("rst_beat20", axis.tdata, 420);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_valid", axis.tvalid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      rst = 1'b0;
      q.delete();
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", dones, 0);
      launch(0, 0);
      finish_check(36, 1, 0, 35);
    end

    begin
      int n = 0;
      launch(3, 4);
      while (beats < 10 && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      start  = 1'b1;
      s_addr = AW'(100);
      b_addr = AW'(200);
      @(posedge clk); #1;
      start  = 1'b0;
      s_addr = AW'(7);
      b_addr = AW'(1);
      check("poke_busy", busy, 1);
      finish_check(72, 2, 300, 435);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
